// File: rtl/ps2_key_tracker_pkg.sv
// Shared definitions for the PS/2 set-2 key tracker: prefix FSM states,
// protocol byte constants and the key-table slot width.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT     = 8'hE0;
   localparam logic [7:0] PS2_BRK     = 8'hF0;
   localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
   localparam logic [7:0] PS2_BAT_ERR = 8'hFC;

   // One key-table slot is {ext, code}
   localparam int SLOT_W = 9;

   // Keyboard self-test completion bytes clear all key state
   function automatic logic is_self_test(input logic [7:0] b);
      return (b == PS2_BAT_OK) || (b == PS2_BAT_ERR);
   endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte input and key-state output bundle of the PS/2 key tracker.
// master = byte source / state consumer, slave = the tracker itself.
interface ps2_key_tracker_if #(
   parameter int NUM_KEYS = 4
);
   logic [7:0]          din;
   logic                rx_done_tick;
   logic [NUM_KEYS-1:0] key_state;
   logic [NUM_KEYS-1:0] make_pulse;
   logic [NUM_KEYS-1:0] break_pulse;
   logic                any_held;
   logic                code_valid;
   logic [7:0]          last_code;
   logic                last_ext;
   logic                last_break;
   logic                timeout_err;

   modport master (
      output din, rx_done_tick,
      input  key_state, make_pulse, break_pulse, any_held, code_valid,
             last_code, last_ext, last_break, timeout_err
   );

   modport slave (
      input  din, rx_done_tick,
      output key_state, make_pulse, break_pulse, any_held, code_valid,
             last_code, last_ext, last_break, timeout_err
   );
endinterface

// File: rtl/ps2_key_tracker_prefix_fsm.sv
// E0/F0 prefix resolver with inter-byte timeout. Decodes each strobed byte
// against the current prefix state; resolve/ext/brk/code/self_test are
// same-cycle decodes of the incoming byte so the top can register the key
// update one cycle after the tick. timeout_err is registered.
module ps2_prefix_fsm
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] din_i,
   input  logic       rx_done_tick_i,
   output logic       resolve_o,
   output logic       ext_o,
   output logic       brk_o,
   output logic [7:0] code_o,
   output logic       self_test_o,
   output logic       timeout_err_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   ps2_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;

   // Next-state, byte decode and timeout; a tick always beats expiry
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      tmo_d       = 1'b0;
      resolve_o   = 1'b0;
      ext_o       = 1'b0;
      brk_o       = 1'b0;
      self_test_o = 1'b0;
      code_o      = din_i;
      if (rx_done_tick_i) begin
         cnt_d = '0;
         unique case (state_q)
            IDLE: begin
               if (din_i == PS2_EXT)        state_d = EXT;
               else if (din_i == PS2_BRK)   state_d = BRK;
               else if (is_self_test(din_i)) self_test_o = 1'b1;
               else                          resolve_o = 1'b1;
            end
            EXT: begin
               if (din_i == PS2_BRK) begin
                  state_d = EXT_BRK;
               end else if (din_i != PS2_EXT) begin
                  resolve_o = 1'b1;
                  ext_o     = 1'b1;
                  state_d   = IDLE;
               end
            end
            BRK: begin
               resolve_o = 1'b1;
               brk_o     = 1'b1;
               state_d   = IDLE;
            end
            EXT_BRK: begin
               resolve_o = 1'b1;
               ext_o     = 1'b1;
               brk_o     = 1'b1;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            tmo_d   = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State, counter and timeout strobe registers
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it sits inside the clocked branch rather than the sensitivity list.
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign timeout_err_o = tmo_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 key tracker: matches resolved codes against NUM_KEYS
// programmable {ext, code} slots and keeps per-slot held/toggle state
// plus one-cycle make/break event pulses.
module ps2_key_tracker
   import ps2_pkg::*;
#(
   parameter int                           NUM_KEYS       = 4,
   parameter logic [NUM_KEYS*SLOT_W-1:0]   KEY_CODES      = {9'h02C, 9'h016, 9'h024, 9'h033},
   parameter logic [NUM_KEYS-1:0]          TOGGLE_MASK    = '0,
   parameter int unsigned                  TIMEOUT_CYCLES = 2_000_000,
   parameter bit                           REPEAT_PULSE   = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   ps2_key_tracker_if.slave bus
);

   logic       resolve, ext, brk, self_test, timeout_err;
   logic [7:0] code;

   ps2_prefix_fsm #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_prefix_fsm (
      .clk            (clk),
      .reset          (reset),
      .din_i          (bus.din),
      .rx_done_tick_i (bus.rx_done_tick),
      .resolve_o      (resolve),
      .ext_o          (ext),
      .brk_o          (brk),
      .code_o         (code),
      .self_test_o    (self_test),
      .timeout_err_o  (timeout_err)
   );

   logic [NUM_KEYS-1:0] match;
   logic [NUM_KEYS-1:0] held_q, held_d;
   logic [NUM_KEYS-1:0] toggle_q, toggle_d;
   logic [NUM_KEYS-1:0] make_q, make_d;
   logic [NUM_KEYS-1:0] break_q, break_d;
   logic                code_valid_q;
   logic [7:0]          last_code_q;
   logic                last_ext_q, last_break_q;

   // One comparator per slot; duplicate entries simply match together
   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_slot
      assign match[i] = resolve && ({ext, code} == KEY_CODES[i*SLOT_W +: SLOT_W]);
   end

   // Per-slot held/toggle update and event pulses
   always_comb begin
      held_d   = held_q;
      toggle_d = toggle_q;
      make_d   = '0;
      break_d  = '0;
      if (self_test) begin
         held_d   = '0;
         toggle_d = '0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (match[i]) begin
               if (!brk) begin
                  if (!held_q[i]) begin
                     held_d[i]   = 1'b1;
                     toggle_d[i] = ~toggle_q[i];
                     make_d[i]   = 1'b1;
                  end else begin
                     make_d[i] = REPEAT_PULSE;
                  end
               end else if (held_q[i]) begin
                  held_d[i]  = 1'b0;
                  break_d[i] = 1'b1;
               end
            end
         end
      end
   end

   // Key state, pulse and last-code registers
   always_ff @(posedge clk) begin
      if (reset) begin
         held_q       <= '0;
         toggle_q     <= '0;
         make_q       <= '0;
         break_q      <= '0;
         code_valid_q <= 1'b0;
         last_code_q  <= '0;
         last_ext_q   <= 1'b0;
         last_break_q <= 1'b0;
      end else begin
         held_q       <= held_d;
         toggle_q     <= toggle_d;
         make_q       <= make_d;
         break_q      <= break_d;
         code_valid_q <= resolve;
         if (resolve) begin
            last_code_q  <= code;
            last_ext_q   <= ext;
            last_break_q <= brk;
         end
      end
   end

   assign bus.key_state   = (TOGGLE_MASK & toggle_q) | (~TOGGLE_MASK & held_q);
   assign bus.make_pulse  = make_q;
   assign bus.break_pulse = break_q;
   assign bus.any_held    = |held_q;
   assign bus.code_valid  = code_valid_q;
   assign bus.last_code   = last_code_q;
   assign bus.last_ext    = last_ext_q;
   assign bus.last_break  = last_break_q;
   assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker. Two instances share one byte stream:
// A toggles slot 1 with repeat pulses off, B has no toggles and repeat
// pulses on. Slots: 0=2C, 1=16, 2=24, 3=E0 75.
module tb_ps2_key_tracker;
   import ps2_pkg::*;

   localparam int NK = 4;
   localparam logic [NK*SLOT_W-1:0] CODES = {9'h175, 9'h024, 9'h016, 9'h02C};

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   sum_a, sum_b;

   always #5 clk = ~clk;

   ps2_key_tracker_if #(.NUM_KEYS(NK)) bus_a ();
   ps2_key_tracker_if #(.NUM_KEYS(NK)) bus_b ();

   ps2_key_tracker #(
      .NUM_KEYS(NK), .KEY_CODES(CODES), .TOGGLE_MASK(4'b0010),
      .TIMEOUT_CYCLES(100), .REPEAT_PULSE(1'b0)
   ) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

   ps2_key_tracker #(
      .NUM_KEYS(NK), .KEY_CODES(CODES), .TOGGLE_MASK(4'b0000),
      .TIMEOUT_CYCLES(100), .REPEAT_PULSE(1'b1)
   ) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; byte is captured at the next posedge and its
   // result is visible when this returns at the following negedge.
   task automatic send(input logic [7:0] b);
      bus_a.din = b; bus_b.din = b;
      bus_a.rx_done_tick = 1'b1; bus_b.rx_done_tick = 1'b1;
      @(negedge clk);
      bus_a.rx_done_tick = 1'b0; bus_b.rx_done_tick = 1'b0;
   endtask

   initial begin
      bus_a.din = '0; bus_b.din = '0;
      bus_a.rx_done_tick = 1'b0; bus_b.rx_done_tick = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst key_state", bus_a.key_state, 0);
      check("rst any_held", bus_a.any_held, 0);
      check("rst code_valid", bus_a.code_valid, 0);
      check("rst last_code", bus_a.last_code, 0);
      check("rst timeout", bus_a.timeout_err, 0);

      // 'T' make then break
      send(8'h2C);
      check("T make_pulse", bus_a.make_pulse, 4'b0001);
      check("T key_state", bus_a.key_state, 4'b0001);
      check("T code_valid", bus_a.code_valid, 1);
      check("T last_code", bus_a.last_code, 8'h2C);
      check("T last_break0", bus_a.last_break, 0);
      send(8'hF0);
      check("F0 no code_valid", bus_a.code_valid, 0);
      check("F0 no make", bus_a.make_pulse, 0);
      send(8'h2C);
      check("T break_pulse", bus_a.break_pulse, 4'b0001);
      check("T released", bus_a.key_state, 0);
      check("T code_valid2", bus_a.code_valid, 1);
      check("T last_break1", bus_a.last_break, 1);

      // Extended up arrow
      send(8'hE0); send(8'h75);
      check("UP make", bus_a.make_pulse, 4'b1000);
      check("UP key_state", bus_a.key_state, 4'b1000);
      check("UP last_ext", bus_a.last_ext, 1);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("UP break", bus_a.break_pulse, 4'b1000);
      check("UP released", bus_a.key_state, 0);
      check("UP last_ext brk", {bus_a.last_ext, bus_a.last_break}, 2'b11);
      send(8'h75);
      check("75 plain valid", bus_a.code_valid, 1);
      check("75 plain no make", bus_a.make_pulse, 0);
      check("75 plain ext0", bus_a.last_ext, 0);
      send(8'hF0); send(8'h75);
      check("75 plain no break", bus_a.break_pulse, 0);

      // Toggle slot 1 on A, held level on B
      send(8'h16);
      check("tg1 A state", bus_a.key_state, 4'b0010);
      check("tg1 make", bus_a.make_pulse, 4'b0010);
      send(8'hF0); send(8'h16);
      check("tg1 A stays", bus_a.key_state, 4'b0010);
      check("tg1 B held lvl", bus_b.key_state, 0);
      check("tg1 break", bus_a.break_pulse, 4'b0010);
      send(8'h16);
      check("tg2 A state", bus_a.key_state, 0);
      check("tg2 B state", bus_b.key_state, 4'b0010);
      check("tg2 make", bus_a.make_pulse, 4'b0010);
      send(8'hF0); send(8'h16);
      check("tg2 break", bus_a.break_pulse, 4'b0010);
      check("tg2 A off", bus_a.key_state, 0);

      // Typematic repeat, full-rate ticks
      sum_a = 0; sum_b = 0;
      for (int k = 0; k < 5; k++) begin
         send(8'h24);
         sum_a += int'(bus_a.make_pulse[2]);
         sum_b += int'(bus_b.make_pulse[2]);
      end
      check("rep A one make", sum_a, 1);
      check("rep B five make", sum_b, 5);
      send(8'hF0); send(8'h24);
      check("rep break", bus_b.break_pulse, 4'b0100);

      // Timeout after an F0 with no following byte
      send(8'hF0);
      repeat (99) @(negedge clk);
      check("tmo not yet", bus_a.timeout_err, 0);
      @(negedge clk);
      check("tmo fires", bus_a.timeout_err, 1);
      check("tmo no valid", bus_a.code_valid, 0);
      @(negedge clk);
      check("tmo one cycle", bus_a.timeout_err, 0);
      send(8'h2C);
      check("after tmo make", bus_a.make_pulse, 4'b0001);
      check("after tmo state", bus_a.key_state, 4'b0001);

      // Tick arriving in the expiry cycle wins
      send(8'hF0);
      repeat (99) @(negedge clk);
      send(8'h2C);
      check("tick wins break", bus_a.break_pulse, 4'b0001);
      check("tick wins no tmo", bus_a.timeout_err, 0);
      @(negedge clk);
      check("tick wins no tmo2", bus_a.timeout_err, 0);

      // Self-test clears held and toggle state
      send(8'h2C); send(8'h33); send(8'h16);
      check("pre bat state", bus_a.key_state, 4'b0011);
      check("pre bat any", bus_a.any_held, 1);
      send(8'hAA);
      check("bat state A", bus_a.key_state, 0);
      check("bat state B", bus_b.key_state, 0);
      check("bat any_held", bus_a.any_held, 0);
      check("bat no valid", bus_a.code_valid, 0);
      send(8'hF0); send(8'h16);
      check("bat no break", bus_a.break_pulse, 0);

      // Reset right after an E0
      send(8'h2C);
      send(8'hE0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst mid key_state", bus_a.key_state, 0);
      check("rst mid any", bus_a.any_held, 0);
      check("rst mid last_code", bus_a.last_code, 0);
      send(8'h75);
      check("rst mid 75 valid", bus_a.code_valid, 1);
      check("rst mid 75 ext0", bus_a.last_ext, 0);
      check("rst mid 75 no make", bus_a.make_pulse, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
